// File: rtl/avalon_st_arbiter_if.sv
// Avalon-ST style stream bundle shared by the arbiter inputs and output.
// The ready field is called rdy; empty counts unused bytes in the final beat.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_W-1:0]               empty;
  logic                             sop;
  logic                             eop;
  logic                             valid;
  logic                             rdy;

  modport master (output data, empty, sop, eop, valid, input rdy);
  modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/avalon_st_arbiter.sv
// Two-input packet arbiter: grants a whole packet (sop..eop) to A or B, alternating on ties.
// Non-sop beats arriving while idle are consumed and flagged via drop_a/drop_b.
module avalon_st_arbiter #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  msg_a,
  avalon_st_if.slave  msg_b,
  avalon_st_if.master arb_msg,
  output logic        grant_a,
  output logic        grant_b,
  output logic        drop_a,
  output logic        drop_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_grant;  // 1'b0 = A granted last, 1'b1 = B granted last
  logic   w_req_a;
  logic   w_req_b;

  assign w_req_a = msg_a.valid & msg_a.sop;
  assign w_req_b = msg_b.valid & msg_b.sop;

  assign grant_a = (r_state == GRANT_A);
  assign grant_b = (r_state == GRANT_B);

  // Packet-level grant state and tie-break history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_a && (!w_req_b || r_last_grant)) begin
            r_state      <= GRANT_A;
            r_last_grant <= 1'b0;
          end else if (w_req_b) begin
            r_state      <= GRANT_B;
            r_last_grant <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT_A: begin
          if (msg_a.valid && msg_a.eop && arb_msg.rdy) r_state <= IDLE;
          else                                         r_state <= GRANT_A;
        end
        GRANT_B: begin
          if (msg_b.valid && msg_b.eop && arb_msg.rdy) r_state <= IDLE;
          else                                         r_state <= GRANT_B;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath mux and handshakes; the idle branch is gated by rst so stray
  // beats are neither accepted nor flagged while reset is held.
  always_comb begin
    arb_msg.valid = 1'b0;
    arb_msg.sop   = 1'b0;
    arb_msg.eop   = 1'b0;
    arb_msg.empty = '0;
    arb_msg.data  = '0;
    msg_a.rdy     = 1'b0;
    msg_b.rdy     = 1'b0;
    drop_a        = 1'b0;
    drop_b        = 1'b0;
    case (r_state)
      IDLE: begin
        drop_a    = rst & msg_a.valid & ~msg_a.sop;
        drop_b    = rst & msg_b.valid & ~msg_b.sop;
        msg_a.rdy = drop_a;
        msg_b.rdy = drop_b;
      end
      GRANT_A: begin
        arb_msg.valid = msg_a.valid;
        arb_msg.sop   = msg_a.sop;
        arb_msg.eop   = msg_a.eop;
        arb_msg.empty = msg_a.empty;
        arb_msg.data  = msg_a.data;
        msg_a.rdy     = arb_msg.rdy;
      end
      GRANT_B: begin
        arb_msg.valid = msg_b.valid;
        arb_msg.sop   = msg_b.sop;
        arb_msg.eop   = msg_b.eop;
        arb_msg.empty = msg_b.empty;
        arb_msg.data  = msg_b.data;
        msg_b.rdy     = arb_msg.rdy;
      end
      default: begin
        arb_msg.valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Directed table-driven bench for avalon_st_arbiter plus a hand-written
// reset-mid-packet sequence; expected values are hand-computed per cycle.
module tb_avalon_st_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic grant_a, grant_b, drop_a, drop_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) a_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) b_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) o_if ();

  avalon_st_arbiter #(.DATA_WIDTH_IN_BYTES(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .msg_a   (a_if),
    .msg_b   (b_if),
    .arb_msg (o_if),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .drop_a  (drop_a),
    .drop_b  (drop_b)
  );

  always #5 clk = ~clk;

  // a/b/eo are {valid,sop,eop}; ef is {a_rdy,b_rdy,grant_a,grant_b,drop_a,drop_b}
  typedef struct {
    logic       r;
    logic [2:0] a;
    logic [7:0] ad;
    logic [2:0] b;
    logic [7:0] bd;
    logic [3:0] be;
    logic       ordy;
    logic [5:0] ef;
    logic [2:0] eo;
    logic [7:0] ed;
    logic [3:0] ee;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] a, input logic [7:0] ad,
                     input logic [2:0] b, input logic [7:0] bd, input logic [3:0] be,
                     input logic ordy, input logic [5:0] ef, input logic [2:0] eo,
                     input logic [7:0] ed, input logic [3:0] ee);
    vec_t v;
    v.r = r; v.a = a; v.ad = ad; v.b = b; v.bd = bd; v.be = be; v.ordy = ordy;
    v.ef = ef; v.eo = eo; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [2:0] a, input logic [7:0] ad,
                       input logic [2:0] b, input logic [7:0] bd, input logic [3:0] be,
                       input logic ordy);
    rst        = r;
    a_if.valid = a[2]; a_if.sop = a[1]; a_if.eop = a[0];
    a_if.data  = {16{ad}}; a_if.empty = 4'd0;
    b_if.valid = b[2]; b_if.sop = b[1]; b_if.eop = b[0];
    b_if.data  = {16{bd}}; b_if.empty = be;
    o_if.rdy   = ordy;
  endtask

  task automatic chk(input string name, input logic [5:0] ef, input logic [2:0] eo,
                     input logic [7:0] ed, input logic [3:0] ee);
    logic [140:0] got;
    logic [140:0] exp;
    got = {a_if.rdy, b_if.rdy, grant_a, grant_b, drop_a, drop_b,
           o_if.valid, o_if.sop, o_if.eop, o_if.data, o_if.empty};
    exp = {ef, eo, {16{ed}}, ee};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    drive(1'b0, 3'b000, 8'h00, 3'b000, 8'h00, 4'd0, 1'b1);

    // reset holds everything low even with stray beats present
    add(1'b0, 3'b100, 8'h00, 3'b100, 8'h00, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    // tie after reset: A 3 beats, one idle, B 3 beats
    add(1'b1, 3'b110, 8'hA1, 3'b110, 8'hB1, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    add(1'b1, 3'b110, 8'hA1, 3'b110, 8'hB1, 4'd0, 1'b1, 6'b101000, 3'b110, 8'hA1, 4'd0);
    add(1'b1, 3'b100, 8'hA2, 3'b110, 8'hB1, 4'd0, 1'b1, 6'b101000, 3'b100, 8'hA2, 4'd0);
    add(1'b1, 3'b101, 8'hA3, 3'b110, 8'hB1, 4'd0, 1'b1, 6'b101000, 3'b101, 8'hA3, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b110, 8'hB1, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b110, 8'hB1, 4'd0, 1'b1, 6'b010100, 3'b110, 8'hB1, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b100, 8'hB2, 4'd0, 1'b1, 6'b010100, 3'b100, 8'hB2, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b101, 8'hB3, 4'd0, 1'b1, 6'b010100, 3'b101, 8'hB3, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b000, 8'h00, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    // four back-to-back single-beat ties: A, B, A, B
    for (int k = 0; k < 2; k++) begin
      add(1'b1, 3'b111, 8'h11, 3'b111, 8'h22, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
      add(1'b1, 3'b111, 8'h11, 3'b111, 8'h22, 4'd0, 1'b1, 6'b101000, 3'b111, 8'h11, 4'd0);
      add(1'b1, 3'b111, 8'h11, 3'b111, 8'h22, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
      add(1'b1, 3'b111, 8'h11, 3'b111, 8'h22, 4'd0, 1'b1, 6'b010100, 3'b111, 8'h22, 4'd0);
    end
    // stray non-sop beats in idle are dropped
    add(1'b1, 3'b100, 8'h5A, 3'b000, 8'h00, 4'd0, 1'b1, 6'b100010, 3'b000, 8'h00, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b100, 8'h5B, 4'd0, 1'b1, 6'b010001, 3'b000, 8'h00, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b000, 8'h00, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    // B 4-beat packet under toggling backpressure, A stray beat blocked
    add(1'b1, 3'b000, 8'h00, 3'b110, 8'hC1, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b110, 8'hC1, 4'd0, 1'b1, 6'b010100, 3'b110, 8'hC1, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b100, 8'hC2, 4'd0, 1'b0, 6'b000100, 3'b100, 8'hC2, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b100, 8'hC2, 4'd0, 1'b1, 6'b010100, 3'b100, 8'hC2, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b000, 8'hC3, 4'd0, 1'b1, 6'b010100, 3'b000, 8'hC3, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b100, 8'hC3, 4'd0, 1'b0, 6'b000100, 3'b100, 8'hC3, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b100, 8'hC3, 4'd0, 1'b1, 6'b010100, 3'b100, 8'hC3, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b101, 8'hC4, 4'd0, 1'b0, 6'b000100, 3'b101, 8'hC4, 4'd0);
    add(1'b1, 3'b100, 8'h77, 3'b101, 8'hC4, 4'd0, 1'b1, 6'b010100, 3'b101, 8'hC4, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b000, 8'h00, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    // single-beat B packet with empty=5
    add(1'b1, 3'b000, 8'h00, 3'b111, 8'hE1, 4'd5, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);
    add(1'b1, 3'b000, 8'h00, 3'b111, 8'hE1, 4'd5, 1'b1, 6'b010100, 3'b111, 8'hE1, 4'd5);
    add(1'b1, 3'b000, 8'h00, 3'b000, 8'h00, 4'd0, 1'b1, 6'b000000, 3'b000, 8'h00, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].a, vecs[i].ad, vecs[i].b, vecs[i].bd, vecs[i].be, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].ef, vecs[i].eo, vecs[i].ed, vecs[i].ee);
    end

    // reset asserted on beat 2 of a 5-beat A packet
    @(negedge clk); drive(1'b1, 3'b110, 8'hD1, 3'b000, 8'h00, 4'd0, 1'b1); #1;
    chk("mid_rst_idle", 6'b000000, 3'b000, 8'h00, 4'd0);
    @(negedge clk); drive(1'b1, 3'b110, 8'hD1, 3'b000, 8'h00, 4'd0, 1'b1); #1;
    chk("mid_rst_beat1", 6'b101000, 3'b110, 8'hD1, 4'd0);
    @(negedge clk); drive(1'b1, 3'b100, 8'hD2, 3'b000, 8'h00, 4'd0, 1'b1); #1;
    chk("mid_rst_beat2", 6'b101000, 3'b100, 8'hD2, 4'd0);
    drive(1'b0, 3'b100, 8'hD2, 3'b000, 8'h00, 4'd0, 1'b1); #1;
    chk("mid_rst_async", 6'b000000, 3'b000, 8'h00, 4'd0);
    @(negedge clk); drive(1'b1, 3'b100, 8'hD3, 3'b111, 8'hB9, 4'd0, 1'b1); #1;
    chk("post_rst_drop", 6'b100010, 3'b000, 8'h00, 4'd0);
    @(negedge clk); drive(1'b1, 3'b000, 8'h00, 3'b111, 8'hB9, 4'd0, 1'b1); #1;
    chk("post_rst_b", 6'b010100, 3'b111, 8'hB9, 4'd0);
    @(negedge clk); drive(1'b1, 3'b000, 8'h00, 3'b000, 8'h00, 4'd0, 1'b1); #1;
    chk("post_rst_idle", 6'b000000, 3'b000, 8'h00, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
